// File: rtl/matrix_scan_ctrl.sv
// Double-buffered 8x8 LED matrix scanner: per-row blanking, 8-level PWM duty, frame-aligned buffer swap.
// All outputs are registered one cycle behind the FSM; writes and swap requests are accepted every cycle.
module matrix_scan_ctrl #(
  parameter int BLANK_CYC = 4,
  parameter int PWM_UNIT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] brightness,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic [7:0] led_row,
  output logic [7:0] led_col,
  output logic       swap_ack,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
  localparam logic [7:0] PWM_LAST   = 8'(PWM_UNIT - 1);

  state_t                 state, state_nxt;
  logic [2:0]             row, row_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic [2:0]             sub, sub_nxt;
  logic [2:0]             bright, bright_nxt;
  logic                   bank, back, pending;
  logic [1:0][7:0][7:0]   fb;
  logic [7:0]             front_row;
  logic                   do_swap, end_frame;
  logic [7:0]             row_d, col_d;

  assign back      = ~bank;
  assign front_row = fb[bank][row];

  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    cnt_nxt    = cnt;
    sub_nxt    = sub;
    bright_nxt = bright;
    do_swap    = 1'b0;
    end_frame  = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      row_nxt   = 3'd0;
      cnt_nxt   = 8'd0;
      sub_nxt   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = BLANK;
          row_nxt    = 3'd0;
          cnt_nxt    = 8'd0;
          sub_nxt    = 3'd0;
          bright_nxt = brightness;
          do_swap    = pending;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = 8'd0;
            sub_nxt   = 3'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        DRIVE: begin
          if (cnt == PWM_LAST) begin
            cnt_nxt = 8'd0;
            sub_nxt = sub + 3'd1;
            if (sub == 3'd7) begin
              // Row slot ends here; the frame boundary is the only safe point to flip buffers.
              state_nxt  = BLANK;
              row_nxt    = row + 3'd1;
              sub_nxt    = 3'd0;
              bright_nxt = brightness;
              if (row == 3'd7) begin
                end_frame = 1'b1;
                do_swap   = pending;
              end
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode depends on state only, so row select and column data always come from the same row.
  always_comb begin
    row_d = 8'hFF;
    col_d = 8'h00;
    if (state == DRIVE) begin
      row_d = ~(8'b1 << row);
      if (sub <= bright) col_d = front_row;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= 3'd0;
      cnt        <= 8'd0;
      sub        <= 3'd0;
      bright     <= 3'd0;
      bank       <= 1'b0;
      pending    <= 1'b0;
      fb         <= '0;
      led_row    <= 8'hFF;
      led_col    <= 8'h00;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      cnt        <= cnt_nxt;
      sub        <= sub_nxt;
      bright     <= bright_nxt;
      led_row    <= row_d;
      led_col    <= col_d;
      swap_ack   <= do_swap;
      frame_done <= end_frame;
      if (do_swap) begin
        bank    <= ~bank;
        pending <= swap_req;
      end else begin
        pending <= pending | swap_req;
      end
      if (wr_en) fb[back][wr_row] <= wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: per-cycle expected row/col/ack/done queued from a frame model.
module tb_matrix_scan_ctrl;

  localparam int BLANK = 4;
  localparam int PWM   = 2;
  localparam int DRV   = 8 * PWM;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] brightness = 3'd7;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       swap_req = 1'b0;
  logic [7:0] led_row, led_col;
  logic       swap_ack, frame_done;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       ack;
    logic       done;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_front[8];
  logic [7:0] m_back[8];
  logic       m_pend;
  logic [2:0] m_bright;
  int         tests = 0;
  int         fails = 0;

  matrix_scan_ctrl #(.BLANK_CYC(BLANK), .PWM_UNIT(PWM)) dut (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req),
    .led_row(led_row), .led_col(led_col), .swap_ack(swap_ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [7:0] r, input logic [7:0] c, input logic a, input logic d);
    exp_t e;
    e.row = r; e.col = c; e.ack = a; e.done = d;
    q.push_back(e);
  endfunction

  function automatic void push_ff(input int n);
    for (int k = 0; k < n; k++) push(8'hFF, 8'h00, 1'b0, 1'b0);
  endfunction

  function automatic void swap_model();
    logic [7:0] t;
    for (int r = 0; r < 8; r++) begin
      t = m_front[r]; m_front[r] = m_back[r]; m_back[r] = t;
    end
  endfunction

  // First output after en rises still reflects IDLE; a pending swap executes on that edge.
  function automatic void push_start();
    push(8'hFF, 8'h00, m_pend, 1'b0);
    if (m_pend) begin
      swap_model();
      m_pend = 1'b0;
    end
  endfunction

  function automatic void push_frame(input logic ack_end);
    logic       last;
    logic [7:0] rsel;
    for (int r = 0; r < 8; r++) begin
      push_ff(BLANK);
      rsel = 8'h01 << r;
      for (int j = 0; j < DRV; j++) begin
        last = (r == 7) && (j == DRV - 1);
        push(~rsel, ((j / PWM) <= int'(m_bright)) ? m_front[r] : 8'h00, last & ack_end, last);
      end
    end
    if (ack_end) begin
      swap_model();
      m_pend = 1'b0;
    end
  endfunction

  task automatic write_back(input int r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = 3'(r); wr_data = d;
    step();
    wr_en = 1'b0;
    m_back[r] = d;
  endtask

  task automatic swap_idle();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({led_row, led_col, swap_ack, frame_done} !== {8'hFF, 8'h00, 2'b00}) begin
      fails++;
      $display("FAIL reset_async: got %h/%h/%b/%b want FF/00/0/0", led_row, led_col, swap_ack, frame_done);
    end
    step(); step();
    tests++;
    if ({led_row, led_col, swap_ack, frame_done} !== {8'hFF, 8'h00, 2'b00}) begin
      fails++;
      $display("FAIL reset_hold: got %h/%h/%b/%b want FF/00/0/0", led_row, led_col, swap_ack, frame_done);
    end
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin m_front[r] = 8'h00; m_back[r] = 8'h00; end
    m_pend = 1'b0;
    m_bright = 3'd7;
    step();
  endtask

  task automatic test_load_and_swap();
    exp_t e;
    int   n;
    for (int r = 0; r < 8; r++) write_back(r, 8'h01 << r);
    swap_idle();
    en = 1'b1;
    push_start();
    push_frame(1'b0);
    push_ff(2);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      step();
      e = q.pop_front();
      tests++;
      if ({led_row, led_col, swap_ack, frame_done} !== e) begin
        fails++;
        $display("FAIL load_swap[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 led_row, led_col, swap_ack, frame_done, e.row, e.col, e.ack, e.done);
      end
      if (i == n - 3) en = 1'b0;
    end
  endtask

  task automatic test_brightness();
    exp_t       e;
    int         n;
    logic [2:0] b;
    for (int r = 0; r < 8; r++) write_back(r, 8'hFF);
    swap_idle();
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 3'd3 : ((t == 1) ? 3'd0 : 3'd7);
      brightness = b;
      m_bright = b;
      en = 1'b1;
      push_start();
      push_frame(1'b0);
      push_ff(2);
      n = q.size();
      for (int i = 0; i < n; i++) begin
        step();
        e = q.pop_front();
        tests++;
        if ({led_row, led_col, swap_ack, frame_done} !== e) begin
          fails++;
          $display("FAIL brightness%0d[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", b, i,
                   led_row, led_col, swap_ack, frame_done, e.row, e.col, e.ack, e.done);
        end
        if (i == n - 3) en = 1'b0;
      end
    end
    brightness = 3'd7;
    m_bright = 3'd7;
  endtask

  task automatic test_swap_collapse();
    exp_t e;
    int   n;
    for (int r = 0; r < 8; r++) write_back(r, 8'h5A ^ 8'(r));
    en = 1'b1;
    push_start();
    m_pend = 1'b1;
    push_frame(1'b1);
    push_frame(1'b0);
    push_ff(2);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      step();
      e = q.pop_front();
      tests++;
      if ({led_row, led_col, swap_ack, frame_done} !== e) begin
        fails++;
        $display("FAIL swap_collapse[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 led_row, led_col, swap_ack, frame_done, e.row, e.col, e.ack, e.done);
      end
      swap_req = (i == 42) || (i == 45) || (i == 50);
      if (i == n - 3) en = 1'b0;
    end
  endtask

  task automatic test_en_drop();
    exp_t e;
    int   stop_i = -1;
    en = 1'b1;
    push_start();
    push_frame(1'b0);
    for (int i = 0; q.size() > 0; i++) begin
      step();
      e = q.pop_front();
      tests++;
      if ({led_row, led_col, swap_ack, frame_done} !== e) begin
        fails++;
        $display("FAIL en_drop[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 led_row, led_col, swap_ack, frame_done, e.row, e.col, e.ack, e.done);
      end
      if (i == 90) en = 1'b0;
      if (i == 91) begin
        q.delete();
        push_ff(3);
      end
      if (i == 94) begin
        en = 1'b1;
        push_start();
        push_frame(1'b0);
        push_ff(2);
        stop_i = i + 161;
      end
      if (i == stop_i) en = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    for (int r = 0; r < 8; r++) write_back(r, 8'hFF);
    swap_idle();
    en = 1'b1;
    push_start();
    push_frame(1'b0);
    for (int i = 0; i <= 131; i++) begin
      step();
      e = q.pop_front();
      tests++;
      if ({led_row, led_col, swap_ack, frame_done} !== e) begin
        fails++;
        $display("FAIL rst_mid_run[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 led_row, led_col, swap_ack, frame_done, e.row, e.col, e.ack, e.done);
      end
      swap_req = (i == 43);
    end
    #2 rst = 1'b1;
    en = 1'b0;
    #1;
    tests++;
    if ({led_row, led_col, swap_ack, frame_done} !== {8'hFF, 8'h00, 2'b00}) begin
      fails++;
      $display("FAIL rst_mid_async: got %h/%h/%b/%b want FF/00/0/0", led_row, led_col, swap_ack, frame_done);
    end
    q.delete();
    for (int r = 0; r < 8; r++) begin m_front[r] = 8'h00; m_back[r] = 8'h00; end
    m_pend = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      tests++;
      if ({led_row, led_col, swap_ack, frame_done} !== {8'hFF, 8'h00, 2'b00}) begin
        fails++;
        $display("FAIL rst_mid_hold[%0d]: got %h/%h/%b/%b want FF/00/0/0", k, led_row, led_col, swap_ack, frame_done);
      end
    end
    rst = 1'b0;
    step();
    en = 1'b1;
    push_start();
    push_frame(1'b0);
    push_ff(2);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      step();
      e = q.pop_front();
      tests++;
      if ({led_row, led_col, swap_ack, frame_done} !== e) begin
        fails++;
        $display("FAIL rst_mid_after[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 led_row, led_col, swap_ack, frame_done, e.row, e.col, e.ack, e.done);
      end
      if (i == n - 3) en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    for (int r = 0; r < 4; r++) write_back(r, 8'h11);
    swap_idle();
    en = 1'b1;
    push_start();
    m_pend = 1'b1;
    m_back[5] = 8'hC3;
    push_frame(1'b1);
    m_pend = 1'b1;
    push_frame(1'b1);
    push_frame(1'b0);
    push_ff(2);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      step();
      e = q.pop_front();
      tests++;
      if ({led_row, led_col, swap_ack, frame_done} !== e) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 led_row, led_col, swap_ack, frame_done, e.row, e.col, e.ack, e.done);
      end
      swap_req = (i == 25) || (i == 159);
      wr_en    = (i == 159);
      wr_row   = 3'd5;
      wr_data  = 8'hC3;
      if (i == n - 3) en = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load_and_swap();
    test_brightness();
    test_swap_collapse();
    test_en_drop();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
